llc_way_scan: RTL and testbench
===============================

LLC_WAY_SCAN -- requirements
Module: llc_way_scan

Interface
REQ-001 SHALL have parameter LLC_WAYS, default `LLC_WAYS, the number of ways in one buffered set.
REQ-002 SHALL have ports clk (in, 1) and rst (in, 1); one clock; rst is synchronous and active-low.
REQ-003 SHALL have start (in, 1), a request to scan the buffered set; accepted only when busy=0.
REQ-004 SHALL have tag (in, llc_tag_t), the lookup tag, latched on accepted start.
REQ-005 SHALL have tags_buf / states_buf / dirty_bits_buf (in, LLC_WAYS x llc_tag_t / llc_state_t / 1), the set buffers, read live.
REQ-006 SHALL have evict_way_buf (in, llc_way_t), the round-robin eviction pointer from the set buffers.
REQ-007 SHALL have out_ready (in, 1), the consumer accept.
REQ-008 SHALL have busy (out, 1), high from the cycle after accepted start until the result is accepted.
REQ-009 SHALL have out_valid (out, 1), the result-valid flag.
REQ-010 SHALL have hit, way, evict, evict_dirty, conflict (out, 1 / llc_way_t / 1 / 1 / 1), the result fields.

Function
REQ-011 SHALL use FSM states IDLE, SCAN_HIT, SCAN_VICT, RESP.
REQ-012 IDLE: start=1 latches tag, clears scan counter i=0 and inv_found, then moves to SCAN_HIT.
REQ-013 SCAN_HIT: examines way i each cycle; hit means states_buf[i]!=INVALID and tags_buf[i]==tag.
REQ-014 On a hit, the block SHALL move to RESP with hit=1, way=i, evict=0, conflict=0.
REQ-015 A hit at way k SHALL give out_valid exactly k+2 cycles after the start cycle.
REQ-016 On a miss at i=LLC_WAYS-1, the block SHALL move to SCAN_VICT with j=0; the counter never wraps inside SCAN_HIT.
REQ-017 SCAN_VICT: candidate v=(evict_way_buf+j) mod LLC_WAYS, using llc_way_t natural wrap; the first v with states_buf[v]!=SD is the victim.
REQ-018 On finding a victim, the block SHALL move to RESP with hit=0, way=v, evict=(states_buf[v]!=INVALID), evict_dirty=evict&dirty_bits_buf[v].
REQ-019 If all LLC_WAYS candidates are SD, the block SHALL move to RESP with conflict=1, way=evict_way_buf, evict=0.
REQ-020 RESP: out_valid=1 and all result fields SHALL stay stable until out_valid&out_ready; then the block returns to IDLE with out_valid=0.
REQ-021 start SHALL be ignored while busy=1; no queuing.
REQ-022 The upstream set buffers SHALL hold tags/states/dirty bits stable while busy=1; the block does not snapshot them.
REQ-023 All outputs SHALL be registered; result fields are updated only on entry to RESP.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE with busy=0, out_valid=0, hit=0, way=0, evict=0, evict_dirty=0, conflict=0, and internal counters=0.
REQ-025 Reset mid-scan or in RESP SHALL abandon the result; no out_valid is produced for that request.

Configuration
REQ-026 The block SHALL support macro LLC_INVALID_FIRST_EN.
REQ-027 With LLC_INVALID_FIRST_EN defined, SCAN_HIT SHALL record the lowest-index way with state INVALID; on a miss with one recorded, it skips SCAN_VICT and goes directly to RESP with way=that index, evict=0.
REQ-028 With LLC_INVALID_FIRST_EN defined, the invalid-way result SHALL have out_valid at start+LLC_WAYS+1.
REQ-029 Without LLC_INVALID_FIRST_EN, a miss SHALL always run SCAN_VICT.

Structure
REQ-030 The FSM state enum llc_way_scan_state_t SHALL live in cache_types.
REQ-031 The state constants INVALID and SD and the width `LLC_WAY_BITS SHALL come from cache_consts; no local redefinition.
REQ-032 The block SHALL be a single module with no sub-module; the counter and comparator are inline.

Verification (LLC_WAYS=16)
REQ-033 Tag 0x1A5 stored at way 5 as VALID, start -> hit=1, way=5, out_valid 7 cycles after start.
REQ-034 Miss; evict_way_buf=14; states of ways 14,15 = SD; way 0 MODIFIED with dirty=1 -> way=0, evict=1, evict_dirty=1 (wrap-around case).
REQ-035 All ways SD, evict_way_buf=3 -> conflict=1, way=3, out_valid at start+33.
REQ-036 With LLC_INVALID_FIRST_EN: miss, ways 2 and 9 INVALID -> way=2, evict=0, out_valid at start+17.
REQ-037 out_ready held low 10 cycles in RESP, start pulsed meanwhile -> fields stable, start ignored, IDLE one cycle after accept.
REQ-038 rst=0 at cycle 4 of a scan -> all outputs 0 next cycle; a new start then scans normally.

Source files
------------

// File: rtl/cache_consts.sv
// Cache-wide constants: geometry macros and coherence state encodings.
// Defines `LLC_WAYS and `LLC_WAY_BITS for every file compiled after this one.
`ifndef LLC_WAYS
`define LLC_WAYS 16
`endif
`ifndef LLC_WAY_BITS
`define LLC_WAY_BITS 4
`endif

package cache_consts;

    localparam int LLC_TAG_BITS   = 12;
    localparam int LLC_STATE_BITS = 3;

    // Coherence states as held in the LLC set buffers
    localparam logic [LLC_STATE_BITS-1:0] INVALID   = 3'd0;
    localparam logic [LLC_STATE_BITS-1:0] VALID     = 3'd1;
    localparam logic [LLC_STATE_BITS-1:0] SHARED    = 3'd2;
    localparam logic [LLC_STATE_BITS-1:0] EXCLUSIVE = 3'd3;
    localparam logic [LLC_STATE_BITS-1:0] MODIFIED  = 3'd4;
    localparam logic [LLC_STATE_BITS-1:0] SD        = 3'd5;  // transient, cannot be evicted

endpackage

// File: rtl/cache_types.sv
// Cache-wide types: tag, state and way index, plus the way-scan FSM states.
package cache_types;

    import cache_consts::*;

    typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
    typedef logic [LLC_STATE_BITS-1:0] llc_state_t;
    typedef logic [`LLC_WAY_BITS-1:0]  llc_way_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN_HIT,
        SCAN_VICT,
        RESP
    } llc_way_scan_state_t;

endpackage

// File: rtl/llc_way_scan.sv
// LLC way scan: walks one buffered set a way per cycle looking for a tag hit,
// then walks from the round-robin pointer to pick a victim (skipping SD ways).
// Optional macro LLC_INVALID_FIRST_EN: on a miss, reuse the lowest INVALID way
// seen during the hit scan and skip the victim walk.
module llc_way_scan
    import cache_consts::*;
    import cache_types::*;
#(
    parameter int LLC_WAYS = `LLC_WAYS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  llc_tag_t                   tag,
    input  llc_tag_t   [LLC_WAYS-1:0]  tags_buf,
    input  llc_state_t [LLC_WAYS-1:0]  states_buf,
    input  logic       [LLC_WAYS-1:0]  dirty_bits_buf,
    input  llc_way_t                   evict_way_buf,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       out_valid,
    output logic                       hit,
    output llc_way_t                   way,
    output logic                       evict,
    output logic                       evict_dirty,
    output logic                       conflict
);

    localparam llc_way_t LAST_WAY = llc_way_t'(LLC_WAYS - 1);

    llc_way_scan_state_t state_q, state_d;
    llc_way_t            cnt_q, cnt_d;
    llc_tag_t            tag_q, tag_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic                hit_q, hit_d;
    llc_way_t            way_q, way_d;
    logic                evict_q, evict_d;
    logic                evict_dirty_q, evict_dirty_d;
    logic                conflict_q, conflict_d;
`ifdef LLC_INVALID_FIRST_EN
    logic                inv_found_q, inv_found_d;
    llc_way_t            inv_way_q, inv_way_d;
    logic                cur_inv;
`endif
    llc_way_t            vict_way;

    // Next-state and result computation; result fields only change on entry to RESP
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        busy_d        = busy_q;
        out_valid_d   = out_valid_q;
        hit_d         = hit_q;
        way_d         = way_q;
        evict_d       = evict_q;
        evict_dirty_d = evict_dirty_q;
        conflict_d    = conflict_q;
`ifdef LLC_INVALID_FIRST_EN
        inv_found_d   = inv_found_q;
        inv_way_d     = inv_way_q;
        cur_inv       = (states_buf[cnt_q] == INVALID);
`endif
        // candidate wraps naturally in the way-index width
        vict_way      = llc_way_t'(evict_way_buf + cnt_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    tag_d   = tag;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN_HIT;
`ifdef LLC_INVALID_FIRST_EN
                    inv_found_d = 1'b0;
`endif
                end
            end
            SCAN_HIT: begin
                if (states_buf[cnt_q] != INVALID && tags_buf[cnt_q] == tag_q) begin
                    state_d       = RESP;
                    out_valid_d   = 1'b1;
                    hit_d         = 1'b1;
                    way_d         = cnt_q;
                    evict_d       = 1'b0;
                    evict_dirty_d = 1'b0;
                    conflict_d    = 1'b0;
                end else begin
`ifdef LLC_INVALID_FIRST_EN
                    if (!inv_found_q && cur_inv) begin
                        inv_found_d = 1'b1;
                        inv_way_d   = cnt_q;
                    end
`endif
                    if (cnt_q == LAST_WAY) begin
`ifdef LLC_INVALID_FIRST_EN
                        if (inv_found_q || cur_inv) begin
                            state_d       = RESP;
                            out_valid_d   = 1'b1;
                            hit_d         = 1'b0;
                            way_d         = inv_found_q ? inv_way_q : cnt_q;
                            evict_d       = 1'b0;
                            evict_dirty_d = 1'b0;
                            conflict_d    = 1'b0;
                        end else begin
                            state_d = SCAN_VICT;
                            cnt_d   = '0;
                        end
`else
                        state_d = SCAN_VICT;
                        cnt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SCAN_VICT: begin
                if (states_buf[vict_way] != SD) begin
                    state_d       = RESP;
                    out_valid_d   = 1'b1;
                    hit_d         = 1'b0;
                    way_d         = vict_way;
                    evict_d       = (states_buf[vict_way] != INVALID);
                    evict_dirty_d = (states_buf[vict_way] != INVALID) & dirty_bits_buf[vict_way];
                    conflict_d    = 1'b0;
                end else if (cnt_q == LAST_WAY) begin
                    // every way is mid-transaction: report a conflict, nothing to evict
                    state_d       = RESP;
                    out_valid_d   = 1'b1;
                    hit_d         = 1'b0;
                    way_d         = evict_way_buf;
                    evict_d       = 1'b0;
                    evict_dirty_d = 1'b0;
                    conflict_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tag_q         <= '0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            hit_q         <= 1'b0;
            way_q         <= '0;
            evict_q       <= 1'b0;
            evict_dirty_q <= 1'b0;
            conflict_q    <= 1'b0;
`ifdef LLC_INVALID_FIRST_EN
            inv_found_q   <= 1'b0;
            inv_way_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tag_q         <= tag_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            hit_q         <= hit_d;
            way_q         <= way_d;
            evict_q       <= evict_d;
            evict_dirty_q <= evict_dirty_d;
            conflict_q    <= conflict_d;
`ifdef LLC_INVALID_FIRST_EN
            inv_found_q   <= inv_found_d;
            inv_way_q     <= inv_way_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign hit         = hit_q;
    assign way         = way_q;
    assign evict       = evict_q;
    assign evict_dirty = evict_dirty_q;
    assign conflict    = conflict_q;

endmodule

// File: tb/tb_llc_way_scan.sv
// Scoreboard bench for llc_way_scan: stimulus pushes model results, a negedge
// monitor pops and compares whenever the DUT presents a result.
`ifndef LLC_WAYS
`define LLC_WAYS 16
`endif
`ifndef LLC_WAY_BITS
`define LLC_WAY_BITS 4
`endif

module tb_llc_way_scan;
    import cache_consts::*;
    import cache_types::*;

    localparam int NW = `LLC_WAYS;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  out_ready = 1'b0;
    llc_tag_t              tag = '0;
    llc_tag_t   [NW-1:0]   tags_buf = '0;
    llc_state_t [NW-1:0]   states_buf = '0;
    logic       [NW-1:0]   dirty_bits_buf = '0;
    llc_way_t              evict_way_buf = '0;
    logic                  busy, out_valid, hit, evict, evict_dirty, conflict;
    llc_way_t              way;

    typedef struct {
        int hit; int way; int evict; int dirty; int conflict; int lat; int start_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   rdy_hold = 1'b0;

    llc_way_scan #(.LLC_WAYS(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .tag(tag),
        .tags_buf(tags_buf), .states_buf(states_buf), .dirty_bits_buf(dirty_bits_buf),
        .evict_way_buf(evict_way_buf), .out_ready(out_ready),
        .busy(busy), .out_valid(out_valid), .hit(hit), .way(way),
        .evict(evict), .evict_dirty(evict_dirty), .conflict(conflict)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Consumer: random backpressure unless a test pins ready low
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rdy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: hit search, then (optionally) first invalid, then round-robin victim
    function automatic exp_t model(input llc_tag_t t);
        exp_t e;
        e = '{hit: 0, way: 0, evict: 0, dirty: 0, conflict: 0, lat: 0, start_cyc: 0};
        for (int k = 0; k < NW; k++)
            if (states_buf[k] != INVALID && tags_buf[k] == t) begin
                e.hit = 1; e.way = k; e.lat = k + 2;
                return e;
            end
`ifdef LLC_INVALID_FIRST_EN
        for (int k = 0; k < NW; k++)
            if (states_buf[k] == INVALID) begin
                e.way = k; e.lat = NW + 1;
                return e;
            end
`endif
        for (int j = 0; j < NW; j++) begin
            int v;
            v = (int'(evict_way_buf) + j) % NW;
            if (states_buf[v] != SD) begin
                e.way = v;
                e.evict = (states_buf[v] != INVALID) ? 1 : 0;
                e.dirty = e.evict & int'(dirty_bits_buf[v]);
                e.lat = NW + j + 2;
                return e;
            end
        end
        e.conflict = 1; e.way = int'(evict_way_buf); e.lat = 2 * NW + 1;
        return e;
    endfunction

    function automatic int pack_fields(input int h, input int w, input int e, input int d, input int c);
        return (h << 12) | (e << 11) | (d << 10) | (c << 9) | w;
    endfunction

    // Monitor: compare every presented result; pop on handshake
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc - sb[0].start_cyc, sb[0].lat);
                        seen = 1'b1;
                    end
                    chk("fields",
                        pack_fields(int'(hit), int'(way), int'(evict), int'(evict_dirty), int'(conflict)),
                        pack_fields(sb[0].hit, sb[0].way, sb[0].evict, sb[0].dirty, sb[0].conflict));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin @(posedge clk); #1; n++; end
        if (busy) chk(name, 1, 0);
    endtask

    task automatic issue(input llc_tag_t t, input bit hold);
        exp_t e;
        int n;
        wait_idle("idle_before_start");
        e = model(t);
        rdy_hold = hold;
        tag = t;
        start = 1'b1;
        e.start_cyc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        if (hold) begin
            n = 0;
            while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
            chk("resp_reached", int'(out_valid), 1);
            repeat (10) begin
                tag = ~t; start = 1'b1;
                @(posedge clk); #1;
            end
            start = 1'b0;
            chk("busy_held_in_resp", int'(busy), 1);
            rdy_hold = 1'b0;
        end
        n = 0;
        while (busy && n < 300) begin @(posedge clk); #1; n++; end
        chk("request_done", int'(busy), 0);
        if (hold) begin
            chk("idle_after_accept_valid", int'(out_valid), 0);
            @(posedge clk); #1;
            chk("start_not_queued", int'(busy), 0);
        end
    endtask

    task automatic fill_valid_miss();
        for (int k = 0; k < NW; k++) begin
            states_buf[k] = VALID;
            tags_buf[k] = llc_tag_t'(12'h800 + k);
            dirty_bits_buf[k] = 1'b0;
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fields", pack_fields(int'(hit), int'(way), int'(evict), int'(evict_dirty), int'(conflict)), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // hit at way 5
        fill_valid_miss();
        tags_buf[5] = 12'h1A5;
        issue(12'h1A5, 1'b0);

        // wrap-around victim: 14,15 SD, way 0 modified and dirty
        fill_valid_miss();
        evict_way_buf = 4'd14;
        states_buf[14] = SD; states_buf[15] = SD;
        states_buf[0] = MODIFIED; dirty_bits_buf[0] = 1'b1;
        issue(12'h1A5, 1'b0);

        // all SD: conflict
        for (int k = 0; k < NW; k++) states_buf[k] = SD;
        evict_way_buf = 4'd3;
        issue(12'h1A5, 1'b0);

        // invalid ways 2 and 9 on a miss
        fill_valid_miss();
        evict_way_buf = 4'd0;
        states_buf[2] = INVALID; states_buf[9] = INVALID;
        issue(12'h1A5, 1'b0);

        // backpressure in RESP with start pulses
        fill_valid_miss();
        tags_buf[3] = 12'h0C3;
        issue(12'h0C3, 1'b1);

        // reset mid-scan abandons the request
        fill_valid_miss();
        wait_idle("idle_before_reset_test");
        tag = 12'h777; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_fields", pack_fields(int'(hit), int'(way), int'(evict), int'(evict_dirty), int'(conflict)), 0);
        repeat (40) @(posedge clk);
        #1;
        tags_buf[7] = 12'h123;
        issue(12'h123, 1'b0);

        // randomized sets
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < NW; k++) begin
                int r;
                r = $urandom_range(0, 9);
                states_buf[k] = (r < 2) ? INVALID : (r < 4) ? VALID : (r < 5) ? SHARED :
                                (r < 7) ? MODIFIED : SD;
                if (it % 10 == 9) states_buf[k] = SD;
                tags_buf[k] = llc_tag_t'($urandom_range(0, 7));
                dirty_bits_buf[k] = 1'($urandom_range(0, 1));
            end
            evict_way_buf = llc_way_t'($urandom_range(0, NW - 1));
            issue(llc_tag_t'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
